// File: rtl/uart_rx_control.sv
// UART byte receiver: start, 8 data bits LSB first, 9th-bit slot, stop; samples each bit mid-bit.
// Define RX_PARITY_EN to check the 9th bit as parity (PARITY_ODD selects odd); otherwise it is a stop bit.
module uart_rx_control #(
   parameter int unsigned BPS_DIV = 5208
`ifdef RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic       CLOCK_50M,
   input  logic       RST_n,
   input  logic       Rx_En_Sig,
   input  logic       Rx_Pin,
   output logic [7:0] Rx_Data,
   output logic       Rx_Done_Sig,
   output logic       Rx_Err_Sig,
   output logic       Rx_Busy
);

   localparam int unsigned CntW = $clog2(BPS_DIV);
   localparam logic [CntW-1:0] BitLast  = CntW'(BPS_DIV - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(BPS_DIV / 2 - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StSlot9, StStop, StDone} state_t;

   state_t          state;
   logic [2:0]      rx_sync;
   logic [CntW-1:0] baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;
   logic            frame_err;
   logic            line;
   logic            line_fall;
   logic            bit_tick;

   // rx_sync[1] is the synchronized line; rx_sync[2] is its previous value for edge detection
   assign line      = rx_sync[1];
   assign line_fall = rx_sync[2] & ~rx_sync[1];
   assign bit_tick  = (baud_cnt == BitLast);

   always_ff @(posedge CLOCK_50M or negedge RST_n) begin
      if (!RST_n) begin
         rx_sync     <= 3'b111;
         state       <= StIdle;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         frame_err   <= 1'b0;
         Rx_Data     <= 8'h00;
         Rx_Done_Sig <= 1'b0;
         Rx_Err_Sig  <= 1'b0;
         Rx_Busy     <= 1'b0;
      end else begin
         rx_sync     <= {rx_sync[1:0], Rx_Pin};
         Rx_Done_Sig <= 1'b0;
         Rx_Err_Sig  <= 1'b0;
         if (!Rx_En_Sig) begin
            state   <= StIdle;
            Rx_Busy <= 1'b0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (line_fall) begin
                     state     <= StStart;
                     baud_cnt  <= '0;
                     bit_idx   <= '0;
                     frame_err <= 1'b0;
                     Rx_Busy   <= 1'b1;
                  end
               end
               StStart: begin
                  if (baud_cnt == HalfLast) begin
                     baud_cnt <= '0;
                     if (line) begin
                        state   <= StIdle;
                        Rx_Busy <= 1'b0;
                     end else begin
                        state <= StData;
                     end
                  end else begin
                     baud_cnt <= baud_cnt + CntW'(1);
                  end
               end
               StData: begin
                  if (bit_tick) begin
                     baud_cnt           <= '0;
                     shift_reg[bit_idx] <= line;
                     if (bit_idx == 3'd7) state <= StSlot9;
                     else bit_idx <= bit_idx + 3'd1;
                  end else begin
                     baud_cnt <= baud_cnt + CntW'(1);
                  end
               end
               StSlot9: begin
                  if (bit_tick) begin
                     baud_cnt <= '0;
                     state    <= StStop;
`ifdef RX_PARITY_EN
                     frame_err <= (line != (^shift_reg ^ PARITY_ODD));
`else
                     frame_err <= ~line;
`endif
                  end else begin
                     baud_cnt <= baud_cnt + CntW'(1);
                  end
               end
               StStop: begin
                  if (bit_tick) begin
                     baud_cnt <= '0;
                     state    <= StDone;
                     if (!line) frame_err <= 1'b1;
                  end else begin
                     baud_cnt <= baud_cnt + CntW'(1);
                  end
               end
               StDone: begin
                  // Leaving mid-stop-bit lets the next frame's start edge be caught immediately
                  Rx_Data     <= shift_reg;
                  Rx_Done_Sig <= 1'b1;
                  Rx_Err_Sig  <= frame_err;
                  Rx_Busy     <= 1'b0;
                  state       <= StIdle;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_control.sv
// Randomized self-checking bench for uart_rx_control with BPS_DIV=16.
// Per-cycle expectations are planned from frame contents before each frame is driven.
module tb_uart_rx_control;

   localparam int unsigned N = 16;
   localparam int unsigned H = N / 2;
   localparam int MAXC = 16384;
   // Pin edge to visible Done: two sync FFs + edge detect register, then half bit + 10 bits + 1
   localparam int LAT = 3 + H + 10 * N + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       pin = 1'b1;
   logic [7:0] rx_data;
   logic       done, err, busy;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   bit       exp_busy[MAXC];
   bit       exp_done[MAXC];
   bit       exp_err[MAXC];
   bit [7:0] exp_data[MAXC];

   int       done_cyc_q[$];
   bit [7:0] done_data_q[$];
   bit       done_err_q[$];
   bit       done_busy_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_control #(
      .BPS_DIV(N)
`ifdef RX_PARITY_EN
      , .PARITY_ODD(1'b0)
`endif
   ) dut (
      .CLOCK_50M  (clk),
      .RST_n      (rst_n),
      .Rx_En_Sig  (en),
      .Rx_Pin     (pin),
      .Rx_Data    (rx_data),
      .Rx_Done_Sig(done),
      .Rx_Err_Sig (err),
      .Rx_Busy    (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cyc_q.push_back(cyc);
         done_data_q.push_back(rx_data);
         done_err_q.push_back(err);
         done_busy_q.push_back(busy);
      end
      if (check_en && cyc < MAXC)
         chk($sformatf("cycle %0d {done,err,busy,data}", cyc), {done, err, busy, rx_data},
             {exp_done[cyc], exp_err[cyc], exp_busy[cyc], exp_data[cyc]});
   end

   function automatic bit s9_good(input bit [7:0] d);
`ifdef RX_PARITY_EN
      return ^d;
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit frame_bad(input bit [7:0] d, input bit s9, input bit sp);
`ifdef RX_PARITY_EN
      return (s9 != ^d) || !sp;
`else
      return !s9 || !sp;
`endif
   endfunction

   task automatic set_busy(input int from, input int to);
      for (int c = from; c <= to; c++) if (c < MAXC) exp_busy[c] = 1'b1;
   endtask

   task automatic set_data_from(input int from, input bit [7:0] v);
      for (int c = from; c < MAXC; c++) exp_data[c] = v;
   endtask

   // kind: 0 normal, 1 enable dropped in data bit 4, 2 reset pulsed in data bit 4,
   // 3 start edge arrives while disabled (enable returns mid start bit)
   task automatic send_frame(input bit [7:0] d, input bit s9, input bit sp, input int kind,
                             input int gap, output int k);
      bit [10:0] bits;
      int e0, dn, ab;
      for (int g = 0; g < gap; g++) begin
         pin = 1'b1;
         @(posedge clk); #1;
      end
      bits = {sp, s9, d, 1'b0};
      k  = cyc;
      e0 = k + 3;
      dn = k + LAT;
      ab = k + 5 * N + H;
      case (kind)
         0: begin
            set_busy(e0, dn - 1);
            if (dn < MAXC) begin
               exp_done[dn] = 1'b1;
               exp_err[dn]  = frame_bad(d, s9, sp);
            end
            set_data_from(dn, d);
         end
         1: set_busy(e0, ab);
         2: begin
            set_busy(e0, ab - 1);
            set_data_from(ab, 8'h00);
         end
         default: ;
      endcase
      if (kind == 3) en = 1'b0;
      for (int t = 0; t < 11 * N; t++) begin
         pin = bits[t / N];
         if (kind == 1 && t == ab - k) en = 1'b0;
         if (kind == 2 && t == ab - k) rst_n = 1'b0;
         if (kind == 2 && t == ab - k + 2) rst_n = 1'b1;
         if (kind == 3 && t == int'(H)) en = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b1;
   endtask

   task automatic false_start(output int k);
      k = cyc;
      set_busy(k + 3, k + 3 + H - 1);
      for (int t = 0; t < 2 * N; t++) begin
         pin = (t < 4) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k, k1, k2, g;
      bit [7:0] d;
      bit s9, sp, prev_sp;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset done", done, 1'b0);
      chk("reset err", err, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset data", rx_data, 8'h00);
      rst_n = 1'b1;
      check_en = 1'b1;

      send_frame(8'hA5, s9_good(8'hA5), 1'b1, 0, 4, k);
      chk("A5 done count", done_cyc_q.size(), 1);
      chk("A5 data", done_data_q[$], 8'hA5);
      chk("A5 err", done_err_q[$], 1'b0);
      chk("A5 busy with done", done_busy_q[$], 1'b0);
      chk("A5 latency", done_cyc_q[$] - k, 172);

      false_start(k);
      chk("false start no done", done_cyc_q.size(), 1);
      chk("false start busy", busy, 1'b0);

      send_frame(8'h3C, s9_good(8'h3C), 1'b0, 0, 2, k);
      chk("3C done count", done_cyc_q.size(), 2);
      chk("3C data", done_data_q[$], 8'h3C);
      chk("3C err", done_err_q[$], 1'b1);

      send_frame(8'h00, s9_good(8'h00), 1'b1, 0, 6, k1);
      send_frame(8'hFF, s9_good(8'hFF), 1'b1, 0, 0, k2);
      chk("b2b done count", done_cyc_q.size(), 4);
      chk("b2b first data", done_data_q[2], 8'h00);
      chk("b2b second data", done_data_q[3], 8'hFF);
      chk("b2b errs", {done_err_q[2], done_err_q[3]}, 2'b00);
      // frames are 11 bits long, so back-to-back completions are 11 bit times apart
      chk("b2b period", done_cyc_q[3] - done_cyc_q[2], 176);

      send_frame(8'h96, s9_good(8'h96), 1'b1, 1, 4, k);
      chk("enable abort no done", done_cyc_q.size(), 4);
      chk("enable abort data held", rx_data, 8'hFF);
      chk("enable abort busy", busy, 1'b0);

      send_frame(8'hF3, 1'b1, 1'b1, 2, 4, k);
      chk("reset abort no done", done_cyc_q.size(), 4);
      chk("reset abort data", rx_data, 8'h00);
      chk("reset abort busy", busy, 1'b0);

      send_frame(8'hFF, 1'b1, 1'b1, 3, 4, k);
      chk("disabled edge no done", done_cyc_q.size(), 4);

`ifdef RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 0, 4, k);
      chk("parity good err", done_err_q[$], 1'b0);
      send_frame(8'h07, 1'b0, 1'b1, 0, 4, k);
      chk("parity bad err", done_err_q[$], 1'b1);
      chk("parity bad data", done_data_q[$], 8'h07);
`endif

      prev_sp = 1'b1;
      for (int i = 0; i < 24; i++) begin
         d  = 8'($urandom);
         s9 = ($urandom_range(0, 3) == 0) ? ~s9_good(d) : s9_good(d);
         sp = ($urandom_range(0, 4) != 0);
         g  = prev_sp ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
         if (prev_sp && $urandom_range(0, 5) == 0) false_start(k);
         send_frame(d, s9, sp, 0, g, k);
         prev_sp = sp;
      end

      pin = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
